// File: rtl/hazard_control_pkg.sv
// Shared types for the LC-3b pipeline hazard control block.
// Register index type, "no destination" index and the hazard FSM state encoding.
package hazard_control_pkg;

    typedef logic [2:0] lc3b_reg;

    // Register index meaning "no destination"; informational only.
    localparam lc3b_reg HZ_NONE_REG = 3'b000;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_IND2 = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_control_perf_counters.sv
// Saturating event counters for stall cycles, load-use bubbles and branch flushes.
// Counters clear on synchronous reset; each bumps once per cycle its event is high.
module hazard_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        bubble,
    input  logic        flush,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_bubbles,
    output logic [15:0] perf_flushes
);

    logic [31:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bubble && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_bubbles      = bubble_cnt_q;
    assign perf_flushes      = flush_cnt_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline register enables for the 5-stage LC-3b core: stall, flush, load-use bubble, LDI/STI sequencing.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control
    import hazard_control_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  lc3b_reg id_sr1,
    input  lc3b_reg id_sr2,
    input  logic    id_uses_sr1,
    input  logic    id_uses_sr2,
    input  logic    exec_mem_read,
    input  logic    exec_reg_write,
    input  lc3b_reg exec_dest,
    input  logic    imem_read,
    input  logic    imem_resp,
    input  logic    dmem_req,
    input  logic    dmem_resp,
    input  logic    mem_indirect,
    input  logic    mem_branch_taken,
    output logic    pc_load,
    output logic    if_id_load,
    output logic    id_ex_load,
    output logic    ex_mem_load,
    output logic    mem_wb_load,
    output logic    id_ex_bubble,
    output logic    if_id_flush,
    output logic    id_ex_flush,
    output logic    ex_mem_flush,
    output logic    mem_ind_phase
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_bubbles,
    output logic [15:0] perf_flushes
`endif
);

    hazard_state_t state_q, state_d;

    logic imiss, dmiss, ind_hold, stall, load_use;

    assign imiss    = imem_read & ~imem_resp;
    assign dmiss    = dmem_req & ~dmem_resp;
    // The pointer fetch of LDI/STI always holds the pipe, even when it hits.
    assign ind_hold = (state_q == HZ_RUN) & mem_indirect & dmem_req;
    assign stall    = imiss | dmiss | ind_hold;
    assign load_use = exec_mem_read & exec_reg_write &
                      ((id_uses_sr1 & (exec_dest == id_sr1)) |
                       (id_uses_sr2 & (exec_dest == id_sr2)));

    always_comb begin
        state_d       = state_q;
        pc_load       = 1'b0;
        if_id_load    = 1'b0;
        id_ex_load    = 1'b0;
        ex_mem_load   = 1'b0;
        mem_wb_load   = 1'b0;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_ind_phase = (state_q == HZ_IND2);

        if (reset) begin
            state_d       = HZ_RUN;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_ind_phase = 1'b0;
        end else begin
            unique case (state_q)
                HZ_RUN:  if (mem_indirect & dmem_resp) state_d = HZ_IND2;
                HZ_IND2: if (dmem_resp & ~imiss)       state_d = HZ_RUN;
                default: state_d = HZ_RUN;
            endcase

            if (stall) begin
                // Everything frozen; the held inputs re-evaluate next cycle.
            end else if (mem_branch_taken) begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                id_ex_load   = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
            end else begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= HZ_RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters u_perf (
        .clk               (clk),
        .reset             (reset),
        .stall             (~reset & stall),
        .bubble            (id_ex_bubble),
        .flush             (~reset & ~stall & mem_branch_taken),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: driver pushes hand-computed output vectors, monitor compares at negedge.
module tb_hazard_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_sr1, id_sr2, exec_dest;
    logic       id_uses_sr1, id_uses_sr2, exec_mem_read, exec_reg_write;
    logic       imem_read, imem_resp, dmem_req, dmem_resp, mem_indirect, mem_branch_taken;
    logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic       id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, mem_ind_phase;

    always #5 clk = ~clk;

    hazard_control dut (
        .clk              (clk),
        .reset            (reset),
        .id_sr1           (id_sr1),
        .id_sr2           (id_sr2),
        .id_uses_sr1      (id_uses_sr1),
        .id_uses_sr2      (id_uses_sr2),
        .exec_mem_read    (exec_mem_read),
        .exec_reg_write   (exec_reg_write),
        .exec_dest        (exec_dest),
        .imem_read        (imem_read),
        .imem_resp        (imem_resp),
        .dmem_req         (dmem_req),
        .dmem_resp        (dmem_resp),
        .mem_indirect     (mem_indirect),
        .mem_branch_taken (mem_branch_taken),
        .pc_load          (pc_load),
        .if_id_load       (if_id_load),
        .id_ex_load       (id_ex_load),
        .ex_mem_load      (ex_mem_load),
        .mem_wb_load      (mem_wb_load),
        .id_ex_bubble     (id_ex_bubble),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_ind_phase    (mem_ind_phase)
    );

    // Vector layout: {pc, if_id, id_ex, ex_mem, mem_wb loads, bubble, if_id/id_ex/ex_mem flush, ind_phase}
    localparam logic [9:0] E_RST    = 10'b00000_0_111_0;
    localparam logic [9:0] E_NORM   = 10'b11111_0_000_0;
    localparam logic [9:0] E_STALL  = 10'b00000_0_000_0;
    localparam logic [9:0] E_LU     = 10'b00111_1_000_0;
    localparam logic [9:0] E_FLUSH  = 10'b11111_0_111_0;
    localparam logic [9:0] E_STALLP = 10'b00000_0_000_1;
    localparam logic [9:0] E_NORMP  = 10'b11111_0_000_1;

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    wire [9:0] got = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                      id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, mem_ind_phase};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, got, e);
            end
        end
    end

    task automatic idle();
        reset = 1'b0;
        id_sr1 = 3'd0; id_sr2 = 3'd0; exec_dest = 3'd0;
        id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0;
        exec_mem_read = 1'b0; exec_reg_write = 1'b0;
        imem_read = 1'b1; imem_resp = 1'b1;
        dmem_req = 1'b0; dmem_resp = 1'b0;
        mem_indirect = 1'b0; mem_branch_taken = 1'b0;
    endtask

    task automatic cyc(input logic [9:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [2:0] s1, input logic u1,
                                input logic [2:0] s2, input logic u2);
        exec_mem_read = 1'b1; exec_reg_write = 1'b1; exec_dest = 3'd1;
        id_sr1 = s1; id_uses_sr1 = u1; id_sr2 = s2; id_uses_sr2 = u2;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(E_RST, "reset0");
        cyc(E_RST, "reset1");
        idle();
        cyc(E_NORM, "post_reset_normal");

        // LDR R1 in EX, ADD R2,R1,R3 in ID
        set_load_use(3'd1, 1'b1, 3'd3, 1'b1);
        cyc(E_LU, "load_use_sr1");
        idle();
        cyc(E_NORM, "after_bubble");
        // Immediate form: sr2 field matches but is not read
        set_load_use(3'd3, 1'b1, 3'd1, 1'b0);
        cyc(E_NORM, "imm_form_no_bubble");
        set_load_use(3'd3, 1'b1, 3'd1, 1'b1);
        cyc(E_LU, "load_use_sr2");
        set_load_use(3'd1, 1'b1, 3'd1, 1'b1);
        exec_reg_write = 1'b0;
        cyc(E_NORM, "no_regwrite_no_bubble");
        idle();

        // I-cache miss for 5 cycles
        imem_resp = 1'b0;
        for (int i = 0; i < 5; i++) cyc(E_STALL, "imiss_stall");
        imem_resp = 1'b1;
        cyc(E_NORM, "imiss_release");

        // Branch beats load-use; stall beats branch
        set_load_use(3'd1, 1'b1, 3'd3, 1'b1);
        mem_branch_taken = 1'b1;
        cyc(E_FLUSH, "branch_over_load_use");
        dmem_req = 1'b1;
        cyc(E_STALL, "stall_over_branch");
        idle();

        // LDI: pointer resp after 3 cycles, final resp after 4 more
        mem_indirect = 1'b1; dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc(E_STALL, "ldi_ptr_wait");
        dmem_resp = 1'b1;
        cyc(E_STALL, "ldi_ptr_resp");
        dmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) cyc(E_STALLP, "ldi_final_wait");
        dmem_resp = 1'b1;
        cyc(E_NORMP, "ldi_final_resp");
        idle();
        cyc(E_NORM, "ldi_back_to_run");

        // IND2 held by an outstanding I-miss
        mem_indirect = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        cyc(E_STALL, "sti_ptr_hit");
        imem_resp = 1'b0;
        cyc(E_STALLP, "ind2_imiss_hold");
        imem_resp = 1'b1;
        cyc(E_NORMP, "ind2_release");
        idle();
        cyc(E_NORM, "ind2_to_run");

        // Reset while in IND2
        mem_indirect = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        cyc(E_STALL, "enter_ind2_again");
        reset = 1'b1; dmem_resp = 1'b0;
        cyc(E_RST, "reset_in_ind2");
        cyc(E_RST, "reset_held");
        reset = 1'b0;
        cyc(E_STALL, "run_after_reset");
        idle();

        // Simultaneous I and D misses
        dmem_req = 1'b1; imem_resp = 1'b0;
        cyc(E_STALL, "both_miss");
        imem_resp = 1'b1;
        cyc(E_STALL, "dmiss_remaining");
        dmem_resp = 1'b1;
        cyc(E_NORM, "both_resolved");
        idle();

        begin : drain
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d pending, expected 0", exp_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
